// File: rtl/nic_link_allocator_if.sv
// Handshake bundle between the fifo_out_buffers and the link allocator.
// The master side owns the requests and the link stall; the slave side returns the grant.
interface nic_link_allocator_if #(
    parameter int N_FIFO_OUT_BUFFER      = 6,
    parameter int N_BITS_FIFO_OUT_BUFFER = 3
);
    logic [N_FIFO_OUT_BUFFER-1:0]      r_la_i;
    logic                              link_stall_i;
    logic                              g_la_o;
    logic [N_BITS_FIFO_OUT_BUFFER-1:0] g_la_fifo_out_buffer_id_o;
    logic [N_FIFO_OUT_BUFFER-1:0]      g_la_onehot_o;

    modport master (
        output r_la_i,
        output link_stall_i,
        input  g_la_o,
        input  g_la_fifo_out_buffer_id_o,
        input  g_la_onehot_o
    );

    modport slave (
        input  r_la_i,
        input  link_stall_i,
        output g_la_o,
        output g_la_fifo_out_buffer_id_o,
        output g_la_onehot_o
    );
endinterface

// File: rtl/nic_link_allocator.sv
// Link-allocation stage: round-robin grant of the NoC output link to one fifo_out_buffer
// per cycle, with an optional burst-hold that keeps the winner for up to HOLD_CYCLES grants.
module nic_link_allocator #(
    parameter int N_FIFO_OUT_BUFFER      = 6,
    parameter int N_BITS_FIFO_OUT_BUFFER = 3,
    parameter int HOLD_CYCLES            = 1,
    parameter int N_BITS_HOLD            = 3
) (
    input logic                 clk,
    input logic                 rst_n,
    nic_link_allocator_if.slave la
);
    localparam int NB = N_BITS_FIFO_OUT_BUFFER;
    localparam int N  = N_FIFO_OUT_BUFFER;

    localparam logic [0:0] ARB  = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    localparam logic [N_BITS_HOLD-1:0] HOLD_LAST = N_BITS_HOLD'(HOLD_CYCLES);

    logic [0:0]             state;
    logic [NB-1:0]          prio_ptr;
    logic [NB-1:0]          owner;
    logic [N_BITS_HOLD-1:0] hold_cnt;

    logic [NB-1:0]          search_start;
    logic [NB-1:0]          winner;
    logic                   found;
    logic                   owner_req;
    logic                   grant;
    logic [NB-1:0]          grant_id;
    logic [N-1:0]           grant_onehot;
    logic [N_BITS_HOLD-1:0] hold_inc;

    // Explicit wrap so non power-of-2 requester counts stay in range.
    function automatic logic [NB-1:0] next_id(input logic [NB-1:0] x);
        return (x == NB'(N - 1)) ? '0 : x + 1'b1;
    endfunction

    assign owner_req    = (state == HOLD) && la.r_la_i[owner];
    assign search_start = (state == HOLD) ? next_id(owner) : prio_ptr;
    assign hold_inc     = hold_cnt + 1'b1;

    always_comb begin
        logic [NB-1:0] idx;
        found  = 1'b0;
        winner = '0;
        idx    = search_start;
        for (int k = 0; k < N; k++) begin
            if (!found && la.r_la_i[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
            idx = next_id(idx);
        end
    end

    // Outputs are forced quiet while reset is held, whatever the requests.
    always_comb begin
        grant    = 1'b0;
        grant_id = '0;
        if (rst_n && !la.link_stall_i) begin
            if (owner_req) begin
                grant    = 1'b1;
                grant_id = owner;
            end else if (found) begin
                grant    = 1'b1;
                grant_id = winner;
            end
        end
    end

    always_comb begin
        grant_onehot = '0;
        if (grant) grant_onehot[grant_id] = 1'b1;
    end

    assign la.g_la_o                    = grant;
    assign la.g_la_fifo_out_buffer_id_o = grant_id;
    assign la.g_la_onehot_o             = grant_onehot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ARB;
            prio_ptr <= '0;
            owner    <= '0;
            hold_cnt <= '0;
        end else if (!la.link_stall_i) begin
            if (owner_req) begin
                hold_cnt <= hold_inc;
                if (hold_inc == HOLD_LAST) begin
                    prio_ptr <= next_id(owner);
                    state    <= ARB;
                end
            end else begin
                // A dropped hold rearbitrates this same cycle starting past the old owner.
                prio_ptr <= search_start;
                state    <= ARB;
                if (found) begin
                    if (HOLD_CYCLES == 1) begin
                        prio_ptr <= next_id(winner);
                    end else begin
                        owner    <= winner;
                        hold_cnt <= N_BITS_HOLD'(1);
                        state    <= HOLD;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_nic_link_allocator.sv
// Bench for nic_link_allocator: one instance in pure round-robin, one with a 3-grant hold,
// each compared every cycle against a queue-free behavioural arbiter model.
module tb_nic_link_allocator;
    localparam int N  = 6;
    localparam int NB = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nic_link_allocator_if #(.N_FIFO_OUT_BUFFER(N), .N_BITS_FIFO_OUT_BUFFER(NB)) if1 ();
    nic_link_allocator_if #(.N_FIFO_OUT_BUFFER(N), .N_BITS_FIFO_OUT_BUFFER(NB)) if3 ();

    nic_link_allocator #(.N_FIFO_OUT_BUFFER(N), .N_BITS_FIFO_OUT_BUFFER(NB),
                         .HOLD_CYCLES(1), .N_BITS_HOLD(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .la(if1.slave));
    nic_link_allocator #(.N_FIFO_OUT_BUFFER(N), .N_BITS_FIFO_OUT_BUFFER(NB),
                         .HOLD_CYCLES(3), .N_BITS_HOLD(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .la(if3.slave));

    int n_chk = 0;
    int n_err = 0;

    // Model state per instance: index 0 -> HOLD_CYCLES=1, index 1 -> HOLD_CYCLES=3.
    int hold_of[2] = '{1, 3};
    int m_ptr[2];
    int m_own[2];
    int m_used[2];
    int wait_c[2][N];
    int max_wait[2];

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ptr[d]  = 0;
            m_own[d]  = -1;
            m_used[d] = 0;
            for (int i = 0; i < N; i++) wait_c[d][i] = 0;
        end
    endtask

    task automatic model_step(input int d, input logic [N-1:0] req, input bit stall,
                              output bit g, output int id);
        int h;
        int c;
        h  = hold_of[d];
        g  = 1'b0;
        id = 0;
        if (stall) return;
        if (m_own[d] >= 0 && req[m_own[d]]) begin
            g  = 1'b1;
            id = m_own[d];
            m_used[d]++;
            if (m_used[d] == h) begin
                m_ptr[d] = (id + 1) % N;
                m_own[d] = -1;
            end
            return;
        end
        if (m_own[d] >= 0) begin
            m_ptr[d] = (m_own[d] + 1) % N;
            m_own[d] = -1;
        end
        for (int k = 0; k < N; k++) begin
            c = (m_ptr[d] + k) % N;
            if (req[c]) begin
                g  = 1'b1;
                id = c;
                break;
            end
        end
        if (g) begin
            if (h == 1) begin
                m_ptr[d] = (id + 1) % N;
            end else begin
                m_own[d]  = id;
                m_used[d] = 1;
            end
        end
    endtask

    task automatic compare(input int d, input logic [N-1:0] req, input bit stall,
                           input logic g_obs, input logic [NB-1:0] id_obs,
                           input logic [N-1:0] oh_obs);
        bit g;
        int id;
        logic [N-1:0] oh_exp;
        model_step(d, req, stall, g, id);
        oh_exp = '0;
        if (g) oh_exp[id] = 1'b1;
        chk($sformatf("g_la[%0d]", d), int'(g_obs), int'(g));
        chk($sformatf("id[%0d]", d), int'(id_obs), g ? id : 0);
        chk($sformatf("onehot[%0d]", d), int'(oh_obs), int'(oh_exp));
        chk($sformatf("req_held[%0d]", d), g_obs ? int'(req[id_obs]) : 1, 1);
        for (int i = 0; i < N; i++) begin
            if (req[i] && !(g && id == i)) begin
                if (g) wait_c[d][i]++;
            end else begin
                wait_c[d][i] = 0;
            end
            if (wait_c[d][i] > max_wait[d]) max_wait[d] = wait_c[d][i];
        end
    endtask

    // One clock: drive after the rising edge, sample on the falling edge.
    task automatic cyc(input logic [N-1:0] r1, input bit s1,
                       input logic [N-1:0] r3, input bit s3);
        @(posedge clk);
        #1;
        if1.r_la_i = r1;  if1.link_stall_i = s1;
        if3.r_la_i = r3;  if3.link_stall_i = s3;
        @(negedge clk);
        compare(0, r1, s1, if1.g_la_o, if1.g_la_fifo_out_buffer_id_o, if1.g_la_onehot_o);
        compare(1, r3, s3, if3.g_la_o, if3.g_la_fifo_out_buffer_id_o, if3.g_la_onehot_o);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        if1.r_la_i = 6'b111111;  if1.link_stall_i = 1'b0;
        if3.r_la_i = 6'b111111;  if3.link_stall_i = 1'b0;
        @(negedge clk);
        chk("rst_g1", int'(if1.g_la_o), 0);
        chk("rst_oh1", int'(if1.g_la_onehot_o), 0);
        chk("rst_g3", int'(if3.g_la_o), 0);
        chk("rst_oh3", int'(if3.g_la_onehot_o), 0);
        model_reset();
        if1.r_la_i = '0;
        if3.r_la_i = '0;
        rst_n = 1'b1;
    endtask

    function automatic int gid(input logic g, input logic [NB-1:0] id);
        return g ? int'(id) : -1;
    endfunction

    initial begin
        int exp_t1[7] = '{0, 1, 2, 3, 4, 5, 0};
        int exp_t4[8] = '{0, -1, 0, 0, 1, 1, 1, 0};
        logic [N-1:0] r1, r3;
        bit s1, s3;
        int bound;

        if1.r_la_i = '0;  if1.link_stall_i = 1'b0;
        if3.r_la_i = '0;  if3.link_stall_i = 1'b0;
        max_wait = '{0, 0};
        model_reset();

        do_reset();
        for (int i = 0; i < 7; i++) begin
            cyc(6'b111111, 1'b0, 6'b111111, 1'b0);
            chk($sformatf("t1_rr%0d", i), gid(if1.g_la_o, if1.g_la_fifo_out_buffer_id_o), exp_t1[i]);
        end

        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(6'b100001, 1'b0, 6'b100001, 1'b0);
            chk($sformatf("t2_wrap%0d", i), gid(if1.g_la_o, if1.g_la_fifo_out_buffer_id_o),
                (i % 2 == 0) ? 0 : 5);
        end

        do_reset();
        cyc(6'b000100, 1'b0, 6'b000100, 1'b0);
        chk("t3_pre", gid(if1.g_la_o, if1.g_la_fifo_out_buffer_id_o), 2);
        for (int i = 0; i < 3; i++) begin
            cyc(6'b001100, 1'b1, 6'b001100, 1'b1);
            chk($sformatf("t3_stall%0d", i), gid(if1.g_la_o, if1.g_la_fifo_out_buffer_id_o), -1);
        end
        cyc(6'b001100, 1'b0, 6'b001100, 1'b0);
        chk("t3_post", gid(if1.g_la_o, if1.g_la_fifo_out_buffer_id_o), 3);

        do_reset();
        for (int i = 0; i < 8; i++) begin
            cyc(6'b000011, 1'b0, 6'b000011, i == 1);
            chk($sformatf("t4_hold%0d", i), gid(if3.g_la_o, if3.g_la_fifo_out_buffer_id_o), exp_t4[i]);
        end

        do_reset();
        cyc(6'b000010, 1'b0, 6'b000010, 1'b0);
        chk("t5_own1", gid(if3.g_la_o, if3.g_la_fifo_out_buffer_id_o), 1);
        cyc(6'b010000, 1'b0, 6'b010000, 1'b0);
        chk("t5_swap", gid(if3.g_la_o, if3.g_la_fifo_out_buffer_id_o), 4);
        for (int i = 0; i < 2; i++) begin
            cyc(6'b010010, 1'b0, 6'b010010, 1'b0);
            chk($sformatf("t5_own4_%0d", i), gid(if3.g_la_o, if3.g_la_fifo_out_buffer_id_o), 4);
        end
        cyc(6'b010010, 1'b0, 6'b010010, 1'b0);
        chk("t5_next", gid(if3.g_la_o, if3.g_la_fifo_out_buffer_id_o), 1);

        do_reset();
        max_wait = '{0, 0};
        for (int i = 0; i < 10000; i++) begin
            r1 = N'($urandom_range(0, 63));
            r3 = N'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) r1 = r1 | 6'b111111;
            s1 = ($urandom_range(0, 7) == 0);
            s3 = ($urandom_range(0, 7) == 0);
            cyc(r1, s1, r3, s3);
        end
        for (int d = 0; d < 2; d++) begin
            bound = hold_of[d] * (N - 1);
            chk($sformatf("starve[%0d]", d), int'(max_wait[d] <= bound), 1);
        end

        do_reset();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
